// File: rtl/io_timer.sv
// Memory-mapped interval timer on the CPU I/O store bus.
// Write-only register file, prescaled 32-bit counter and a level interrupt.
module io_timer #(
    parameter logic [9:0] BASE_ADR = 10'h040,
    parameter int         PRE_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  st_we_io,
    input  logic [9:0]  st_adr_io,
    input  logic [31:0] st_data_io,
    output logic        interrupt_0,
    output logic [31:0] timer_cnt
);

    logic [9:0]       off_s;
    logic             sel_s;
    logic             wr_any_s;
    logic             ctrl_wr_s;
    logic             period_wr_s;
    logic             clear_wr_s;
    logic             pre_wr_s;
    logic [31:0]      be_mask_s;
    logic             tick_s;
    logic             match_s;
    logic             restart_s;
    logic [31:0]      cnt_inc_s;

    logic             en_r, periodic_r, irq_en_r, pending_r, irq_r;
    logic [31:0]      period_r, cnt_r;
    logic [PRE_W-1:0] prescale_r, pre_cnt_r;

    logic             en_nxt_s, periodic_nxt_s, irq_en_nxt_s, pending_nxt_s, irq_nxt_s;
    logic [31:0]      period_nxt_s, cnt_nxt_s;
    logic [PRE_W-1:0] prescale_nxt_s, pre_cnt_nxt_s;

    // Address decode relative to the register window base
    always_comb begin
        off_s       = st_adr_io - BASE_ADR;
        sel_s       = (off_s[9:2] == 8'd0);
        wr_any_s    = (st_we_io != 4'b0000);
        ctrl_wr_s   = sel_s && (off_s[1:0] == 2'd0) && st_we_io[0];
        period_wr_s = sel_s && (off_s[1:0] == 2'd1) && wr_any_s;
        clear_wr_s  = sel_s && (off_s[1:0] == 2'd2) && st_we_io[0] && st_data_io[0];
        pre_wr_s    = sel_s && (off_s[1:0] == 2'd3) && wr_any_s;
        be_mask_s   = {{8{st_we_io[3]}}, {8{st_we_io[2]}}, {8{st_we_io[1]}}, {8{st_we_io[0]}}};
    end

    // Tick, match and restart qualification for the counting datapath
    always_comb begin
        cnt_inc_s = cnt_r + 32'd1;
        tick_s    = en_r && (pre_cnt_r == prescale_r);
        // a zero period would otherwise match on the 0xFFFFFFFF wrap
        match_s   = tick_s && (period_r != 32'd0) && (cnt_inc_s == period_r);
        restart_s = period_wr_s || (ctrl_wr_s && st_data_io[0] && !en_r);
    end

    // Next-state computation for registers, prescaler, counter and interrupt
    always_comb begin
        en_nxt_s       = en_r;
        periodic_nxt_s = periodic_r;
        irq_en_nxt_s   = irq_en_r;
        period_nxt_s   = period_r;
        prescale_nxt_s = prescale_r;
        pending_nxt_s  = pending_r;
        cnt_nxt_s      = cnt_r;
        pre_cnt_nxt_s  = pre_cnt_r;

        // a CTRL store overrides the one-shot auto-disable
        if (ctrl_wr_s) begin
            en_nxt_s       = st_data_io[0];
            periodic_nxt_s = st_data_io[1];
            irq_en_nxt_s   = st_data_io[2];
        end else if (match_s && !periodic_r) begin
            en_nxt_s = 1'b0;
        end else begin
            en_nxt_s = en_r;
        end

        if (period_wr_s) begin
            period_nxt_s = (period_r & ~be_mask_s) | (st_data_io & be_mask_s);
        end else begin
            period_nxt_s = period_r;
        end

        if (pre_wr_s) begin
            prescale_nxt_s = (prescale_r & ~be_mask_s[PRE_W-1:0])
                           | (st_data_io[PRE_W-1:0] & be_mask_s[PRE_W-1:0]);
        end else begin
            prescale_nxt_s = prescale_r;
        end

        if (match_s) begin
            pending_nxt_s = 1'b1;
        end else if (clear_wr_s) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end

        if (restart_s) begin
            cnt_nxt_s     = 32'd0;
            pre_cnt_nxt_s = {PRE_W{1'b0}};
        end else if (tick_s) begin
            cnt_nxt_s     = match_s ? 32'd0 : cnt_inc_s;
            pre_cnt_nxt_s = {PRE_W{1'b0}};
        end else if (en_r) begin
            cnt_nxt_s     = cnt_r;
            pre_cnt_nxt_s = pre_cnt_r + {{(PRE_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s     = cnt_r;
            pre_cnt_nxt_s = pre_cnt_r;
        end

        irq_nxt_s = pending_nxt_s && irq_en_nxt_s;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r       <= 1'b0;
            periodic_r <= 1'b0;
            irq_en_r   <= 1'b0;
            period_r   <= 32'd0;
            prescale_r <= {PRE_W{1'b0}};
            pending_r  <= 1'b0;
            cnt_r      <= 32'd0;
            pre_cnt_r  <= {PRE_W{1'b0}};
            irq_r      <= 1'b0;
        end else begin
            en_r       <= en_nxt_s;
            periodic_r <= periodic_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            period_r   <= period_nxt_s;
            prescale_r <= prescale_nxt_s;
            pending_r  <= pending_nxt_s;
            cnt_r      <= cnt_nxt_s;
            pre_cnt_r  <= pre_cnt_nxt_s;
            irq_r      <= irq_nxt_s;
        end
    end

    assign interrupt_0 = irq_r;
    assign timer_cnt   = cnt_r;

endmodule

// File: tb/tb_io_timer.sv
// Directed self-checking bench for io_timer.
module tb_io_timer;

    localparam logic [9:0] BASE = 10'h040;

    logic        clk;
    logic        rst;
    logic [3:0]  st_we_io;
    logic [9:0]  st_adr_io;
    logic [31:0] st_data_io;
    logic        interrupt_0;
    logic [31:0] timer_cnt;

    int n_assert;
    int n_fail;

    io_timer #(.BASE_ADR(BASE), .PRE_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_we_io    (st_we_io),
        .st_adr_io   (st_adr_io),
        .st_data_io  (st_data_io),
        .interrupt_0 (interrupt_0),
        .timer_cnt   (timer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // store at the next rising edge; returns 1ns after that edge
    task automatic wr(input logic [9:0] off, input logic [31:0] data, input logic [3:0] we);
        @(negedge clk);
        st_adr_io  = BASE + off;
        st_data_io = data;
        st_we_io   = we;
        @(posedge clk);
        #1;
        st_we_io = 4'b0000;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        st_we_io   = 4'b0000;
        st_adr_io  = 10'd0;
        st_data_io = 32'd0;
        step(3);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("reset_irq", {31'd0, interrupt_0}, 32'd0);
        chk("reset_cnt", timer_cnt, 32'd0);

        // out-of-window stores
        wr(10'd4, 32'h0000_0007, 4'b1111);
        wr(10'd5, 32'h0000_0003, 4'b1111);
        wr(10'd7, 32'h0000_0000, 4'b1111);
        step(10);
        chk("oow_cnt", timer_cnt, 32'd0);
        chk("oow_irq", {31'd0, interrupt_0}, 32'd0);

        // one-shot, P=0, N=5
        wr(10'd3, 32'd0, 4'b1111);
        wr(10'd1, 32'd5, 4'b1111);
        wr(10'd0, 32'h5, 4'b1111);
        step(4);
        chk("os_cnt4", timer_cnt, 32'd4);
        chk("os_pre_irq", {31'd0, interrupt_0}, 32'd0);
        step(1);
        chk("os_rise", {31'd0, interrupt_0}, 32'd1);
        chk("os_cnt_wrap", timer_cnt, 32'd0);
        step(3);
        chk("os_stopped_cnt", timer_cnt, 32'd0);
        chk("os_irq_held", {31'd0, interrupt_0}, 32'd1);
        wr(10'd2, 32'd1, 4'b0001);
        chk("os_clear", {31'd0, interrupt_0}, 32'd0);

        // periodic, P=3, N=4: rises every 16 cycles
        wr(10'd3, 32'd3, 4'b1111);
        wr(10'd1, 32'd4, 4'b1111);
        wr(10'd0, 32'h7, 4'b1111);
        for (int k = 1; k <= 3; k++) begin
            step((k == 1) ? 15 : 14);
            chk("per_pre_irq", {31'd0, interrupt_0}, 32'd0);
            chk("per_pre_cnt", timer_cnt, 32'd3);
            step(1);
            chk("per_rise", {31'd0, interrupt_0}, 32'd1);
            if (k < 3) begin
                wr(10'd2, 32'd1, 4'b0001);
                chk("per_clear", {31'd0, interrupt_0}, 32'd0);
            end
        end
        step(8);
        chk("mid_cnt", timer_cnt, 32'd2);
        chk("mid_irq", {31'd0, interrupt_0}, 32'd1);

        // asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        chk("arst_irq", {31'd0, interrupt_0}, 32'd0);
        chk("arst_cnt", timer_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(5);
        chk("post_rst_cnt", timer_cnt, 32'd0);

        // masking, P=0, N=2, periodic without irq_en
        wr(10'd1, 32'd2, 4'b1111);
        wr(10'd0, 32'h3, 4'b1111);
        step(2);
        chk("mask_irq", {31'd0, interrupt_0}, 32'd0);
        chk("mask_cnt", timer_cnt, 32'd0);
        wr(10'd0, 32'h7, 4'b1111);
        chk("unmask_irq", {31'd0, interrupt_0}, 32'd1);
        chk("unmask_cnt", timer_cnt, 32'd1);

        // CLEAR on the match edge loses to the set
        wr(10'd2, 32'd1, 4'b0001);
        chk("coll_irq", {31'd0, interrupt_0}, 32'd1);
        wr(10'd2, 32'd1, 4'b0001);
        chk("coll_clear", {31'd0, interrupt_0}, 32'd0);
        chk("coll_cnt", timer_cnt, 32'd1);
        wr(10'd0, 32'h0, 4'b1111);
        step(3);
        chk("frozen_cnt", timer_cnt, 32'd0);

        // PERIOD write on a tick cycle, P=3
        wr(10'd3, 32'd3, 4'b1111);
        wr(10'd1, 32'd10, 4'b1111);
        wr(10'd0, 32'h1, 4'b1111);
        step(3);
        chk("tp_cnt0", timer_cnt, 32'd0);
        step(1);
        chk("tp_cnt1", timer_cnt, 32'd1);
        step(3);
        wr(10'd1, 32'd10, 4'b1111);
        chk("tp_restart", timer_cnt, 32'd0);
        step(4);
        chk("tp_after", timer_cnt, 32'd1);

        // byte enables on PERIOD
        wr(10'd0, 32'h0, 4'b1111);
        wr(10'd3, 32'd0, 4'b1111);
        wr(10'd1, 32'hFFFF_FFFF, 4'b1111);
        wr(10'd0, 32'h1, 4'b1111);
        step(5);
        chk("be_cnt5", timer_cnt, 32'd5);
        wr(10'd1, 32'h0000_0010, 4'b0001);
        chk("be_restart", timer_cnt, 32'd0);
        step(16);
        chk("be_cnt16", timer_cnt, 32'd16);
        step(1);
        chk("be_cnt17", timer_cnt, 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/io_timer.md
# io_timer

Memory-mapped interval timer on the CPU I/O store bus, alongside the LED I/O block. It decodes the CPU's I/O store port (`st_adr_io`, `st_we_io`, `st_data_io`), counts prescaled clock ticks against a programmed period, and drives the CPU's `interrupt_0` input. The block is write-only from the CPU, because the I/O port has no read path; pending interrupts are acknowledged by a store.

## Interface
- `BASE_ADR`, default 10'h040: word address in `st_adr_io[11:2]` of register 0; registers occupy `BASE_ADR+0..+3`.
- `PRE_W`, default 16: prescaler width.
- `clk` in 1: system clock (PLL output).
- `rst` in 1: reset, asynchronous, active-high.
- `st_we_io` in 4: byte write enables for the I/O store. A write occurs when any bit is 1.
- `st_adr_io` in 10: I/O word address, bits [11:2].
- `st_data_io` in 32: I/O store data.
- `interrupt_0` out 1: level interrupt to the CPU, equal to `pending & irq_en`, both registered.
- `timer_cnt` out 32: current count, for debug.

## Operation
- Registers (word offset from `BASE_ADR`):
  - +0 CTRL, byte 0 only: bit0 `en`, bit1 `periodic`, bit2 `irq_en`.
  - +1 PERIOD, 32 bits, per-byte enables honoured.
  - +2 CLEAR: a write with `st_data_io[0]=1` (byte 0 enabled) clears `pending`. Nothing is stored.
  - +3 PRESCALE, bits [PRE_W-1:0], per-byte enables honoured.
- Addresses outside the 4-word window are ignored. Disabled bytes leave the register bytes unchanged.
- Prescaler:
  - `pre_cnt` counts 0..PRESCALE while `en`=1.
  - `tick` is true in a cycle where `en`=1 and `pre_cnt==PRESCALE`; in that cycle `pre_cnt` wraps to 0.
  - With PRESCALE=0, `tick` is true every cycle.
- Counter, on a tick:
  - If `cnt+1 == PERIOD`: `cnt`<=0, `pending`<=1, and if `periodic`=0 then `en`<=0 (one-shot).
  - Otherwise `cnt`<=`cnt+1` (32-bit).
- PERIOD=0 never matches. The counter free-runs and wraps 0xFFFFFFFF→0 without setting `pending`.
- Restart conditions:
  - A CTRL write that changes `en` from 0 to 1 zeroes `cnt` and `pre_cnt`.
  - Any PERIOD write zeroes `cnt` and `pre_cnt`.
  - Writing `en`=0 freezes `cnt`; `pending` is kept.
- Simultaneous events:
  - A match and a CLEAR write in the same cycle: `pending` ends at 1 (set wins).
  - A match and a CTRL write in the same cycle: the CTRL write data wins for `en`.
  - A tick and a PERIOD write in the same cycle: the write wins (`cnt`=0).
- `irq_en`=0 masks `interrupt_0` only. `pending` still latches and appears on `interrupt_0` when `irq_en` is later set.
- Reset values: `en`/`periodic`/`irq_en`=0, PERIOD=0, PRESCALE=0, `cnt`=0, `pre_cnt`=0, `pending`=0, `interrupt_0`=0, `timer_cnt`=0.
- Reset mid-count aborts immediately, and all state returns to the reset values asynchronously.

## Timing
- Register writes take effect at the rising edge where `st_we_io`≠0. The new value is visible from the next cycle.
- With PRESCALE=P and PERIOD=N (N≥1), `en` written at edge E0:
  - ticks occur at edges E0+(P+1)·k, for k≥1;
  - `pending` sets at edge E0+(P+1)·N;
  - `interrupt_0` rises in the same cycle (no extra stage after `pending`).
- Periodic mode: subsequent matches occur every (P+1)·N cycles with no slip, including across a CLEAR.
- CLEAR write at edge Ec: `interrupt_0` is low from Ec, unless a match occurs at Ec.
- No stall or handshake exists: a store is accepted in one cycle, every cycle.

## Test plan
- Reset then idle: assert `rst` mid-cycle → `interrupt_0`=0 and `timer_cnt`=0 immediately; stores to address `BASE_ADR+4` leave all state unchanged.
- One-shot: PRESCALE=0, PERIOD=5, CTRL=0x5 → `interrupt_0` rises exactly 5 cycles after the CTRL write edge; `en` clears; `timer_cnt` stays 0; CLEAR=1 drops the interrupt next cycle.
- Periodic with prescale: PRESCALE=3, PERIOD=4, CTRL=0x7, CLEAR after each rise → rises at +16, +32, +48 cycles from the enable edge.
- Masking: CTRL=0x3, PERIOD=2, wait for the match → `interrupt_0`=0; then write CTRL=0x7 → `interrupt_0`=1 in the next cycle.
- Collision: arrange a CLEAR in the exact match cycle → `interrupt_0` remains 1. Then a PERIOD write on a tick cycle → `timer_cnt`=0 in the next cycle.
- Byte enables: PERIOD=0xFFFFFFFF, then write 0x00000010 with `st_we_io`=4'b0001 → PERIOD=0xFFFFFF10, and the counter restarts from 0.
